// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-arbiter state type.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 6;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 64;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus winner index.
// The search starts at rr_ptr and wraps modulo N_REQ.
module rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int unsigned idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % N_REQ;
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among N_REQ writeback sources,
// clears all registers after reset, and tracks outstanding writes.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned ADDR_W         = REG_ADDR_W,
  parameter int unsigned DATA_W         = REG_DATA_W,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned MASK_R0        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic [NUM_REGS-1:0]       pending,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      init_done
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cnt;
  logic [IDX_W-1:0]    rr_ptr, win_idx;
  logic [N_REQ-1:0]    arb_gnt;
  logic                arb_valid;
  logic                grant;
  logic                win_masked;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] pending_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .winner (win_idx),
    .valid  (arb_valid)
  );

  // A grant raised while rst is high would be discarded, so never show it.
  always_comb begin
    grant      = arb_valid && (state == ST_RUN) && !rst;
    gnt        = grant ? arb_gnt : '0;
    win_addr   = '0;
    win_data   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    win_masked = (MASK_R0 != 0) && (win_addr == '0);
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && cnt == ADDR_W'(NUM_REGS - 1)) state_next = ST_RUN;
  end

  // Clear is applied before set so a same-cycle reserve wins.
  always_comb begin
    pending_next = pending;
    if (grant) pending_next[win_addr] = 1'b0;
    if (state == ST_RUN && rsv_valid && !((MASK_R0 != 0) && rsv_addr == '0))
      pending_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt             <= '0;
      rr_ptr          <= '0;
      pending         <= '0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      init_done       <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state_next == ST_RUN);
      pending   <= pending_next;
      if (state == ST_INIT) begin
        rf_write_enable <= 1'b1;
        rf_write_addr   <= cnt;
        rf_write_data   <= '0;
        cnt             <= (cnt == ADDR_W'(NUM_REGS - 1)) ? '0 : cnt + 1'b1;
      end else if (grant) begin
        rf_write_enable <= !win_masked;
        rf_write_addr   <= win_addr;
        rf_write_data   <= win_data;
        rr_ptr          <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        rf_write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a
// behavioural model of the sweep, round-robin order and scoreboard.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic [63:0]     pending;
  logic            rf_write_enable;
  logic [AW-1:0]   rf_write_addr;
  logic [DW-1:0]   rf_write_data;
  logic            init_done;

  regfile_write_arbiter #(
    .N_REQ          (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CLEAR_ON_RESET (1),
    .MASK_R0        (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .gnt             (gnt),
    .rsv_valid       (rsv_valid),
    .rsv_addr        (rsv_addr),
    .pending         (pending),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .init_done       (init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = r_addr[i];
      req_data[i*DW +: DW] = r_data[i];
    end
  end

  // Register file as the DUT drives it: samples on the falling edge.
  logic [DW-1:0] rf_mem [64];
  always @(negedge clk) if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;

  // Reference model state
  bit            m_init;
  int            m_cnt;
  int            m_rr;
  logic [63:0]   m_pend;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_done;
  logic [DW-1:0] exp_mem [64];
  int            wait_cnt [N];
  logic [N-1:0]  g_obs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_winner();
    if (rst || m_init) return -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int w);
    for (int i = 0; i < N; i++) begin
      if (rst || m_init || !req[i]) wait_cnt[i] = 0;
      else if (g_obs[i]) begin
        check($sformatf("fairness%0d", i), 64'(wait_cnt[i] < N), 64'(1));
        wait_cnt[i] = 0;
      end else wait_cnt[i]++;
    end
    if (rst) begin
      m_init = 1; m_cnt = 0; m_rr = 0; m_pend = '0;
      m_we = 0; m_addr = '0; m_data = '0; m_done = 0;
    end else if (m_init) begin
      m_we = 1; m_addr = AW'(m_cnt); m_data = '0;
      exp_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == 64) begin m_cnt = 0; m_init = 0; end
      m_done = !m_init;
    end else begin
      if (w >= 0) begin
        m_addr = r_addr[w];
        m_data = r_data[w];
        m_we   = (r_addr[w] != 0);
        m_rr   = (w + 1) % N;
        m_pend[r_addr[w]] = 1'b0;
        if (m_we) exp_mem[m_addr] = m_data;
      end else m_we = 0;
      if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      m_done = 1;
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    int w;
    logic [N-1:0] eg;
    #1;
    w  = model_winner();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    g_obs = gnt;
    check("gnt", 64'(gnt), 64'(eg));
    @(posedge clk);
    model_update(w);
    #1;
    check("we",        64'(rf_write_enable), 64'(m_we));
    check("waddr",     64'(rf_write_addr),   64'(m_addr));
    check("wdata",     64'(rf_write_data),   64'(m_data));
    check("pending",   pending,              m_pend);
    check("init_done", 64'(init_done),       64'(m_done));
  endtask

  // Read a register after the falling edge that follows the last step.
  task automatic peek(input int a);
    #5;
    check($sformatf("rf[%0d]", a), 64'(rf_mem[a]), 64'(exp_mem[a]));
  endtask

  task automatic set_req(input int i, input logic on, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]    = on;
    r_addr[i] = a;
    r_data[i] = d;
  endtask

  task automatic clear_inputs();
    req = '0; rsv_valid = 0; rsv_addr = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_data[i] = '0; end
  endtask

  task automatic run_init();
    rst = 0; req = '1; rsv_valid = 1; rsv_addr = 6'd9;
    for (int c = 0; c < 64; c++) begin
      rsv_addr = AW'($urandom_range(1, 63));
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    m_init = 1; m_cnt = 0; m_rr = 0; m_pend = '0;
    clear_inputs();
    rst = 1;
    step();
    step();
    run_init();
    peek(37);

    // Three requesters held together rotate 0,1,2,0,...
    set_req(0, 1, 6'd5, 32'hA);
    set_req(1, 1, 6'd6, 32'hB);
    set_req(2, 1, 6'd7, 32'hC);
    for (int c = 0; c < 6; c++) step();
    peek(5);
    clear_inputs();

    // Lone requester 2, then 0 and 2 together
    set_req(2, 1, 6'd10, 32'h1234_5678);
    for (int c = 0; c < 4; c++) step();
    set_req(0, 1, 6'd11, 32'h0BAD_F00D);
    step();
    peek(11);
    clear_inputs();
    step();

    // Scoreboard reserve/release and same-cycle set-wins
    rsv_valid = 1; rsv_addr = 6'd12; step();
    rsv_valid = 0; set_req(0, 1, 6'd12, 32'h12); step();
    rsv_valid = 1; rsv_addr = 6'd20; set_req(0, 1, 6'd20, 32'h20); step();
    clear_inputs(); step();

    // Address 0 is granted but never written or reserved
    set_req(1, 1, 6'd0, 32'hFFFF);
    rsv_valid = 1; rsv_addr = 6'd0;
    step();
    peek(0);
    clear_inputs(); step();

    // Random traffic; requests held until granted
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || g_obs[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom);
        end
      end
      rsv_valid = 1'($urandom_range(0, 2) == 0);
      rsv_addr  = AW'($urandom_range(0, 63));
      step();
      if (c % 50 == 49) peek($urandom_range(0, 63));
    end
    clear_inputs(); step();

    // Reset during traffic with a pending reservation
    rsv_valid = 1; rsv_addr = 6'd3; step();
    rsv_valid = 0;
    set_req(0, 1, 6'd4, 32'h44);
    set_req(2, 1, 6'd8, 32'h88);
    rst = 1;
    step();
    run_init();
    peek(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
